fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 9'h000, PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 run_en  input  1  level; high permits fetching, low parks unit in IDLE after current instruction.
REQ-005 rom_addr  output  9  program ROM byte address.
REQ-006 rom_rd_en  output  1  ROM read strobe; ROM returns rom_data one cycle after strobe.
REQ-007 rom_data  input  8  ROM read data, valid the cycle after rom_rd_en.
REQ-008 instr_byte, operand1, operand2  output  8 each  fetched opcode and two following bytes, to decoder.
REQ-009 cmd_start  output  1  one-cycle pulse: instruction bytes valid, decoder may begin.
REQ-010 exec_done  input  1  decoder finished current instruction; samples instr_size, jmp_en, jmp_addr, pc_hlt this cycle.
REQ-011 instr_size  input  2  instruction length in bytes (1..3) from decoder.
REQ-012 jmp_en  input  1  take branch to jmp_addr.
REQ-013 jmp_addr  input  9  branch target.
REQ-014 pc_hlt  input  1  halt request from decoder.
REQ-015 pc  output  9  address of current instruction's opcode.
REQ-016 halted  output  1  high while in HALT state.
REQ-017 retired  output  16  count of completed instructions, saturating at 16'hFFFF.

Function
REQ-018 States: IDLE, F0, F1, F2, F3, ISSUE, EXEC, HALT; one-hot or binary encoding free.
REQ-019 IDLE: rom_rd_en=0; go to F0 when run_en=1, else stay.
REQ-020 F0: rom_addr=pc, rom_rd_en=1; next F1.
REQ-021 F1: rom_addr=pc+1, rom_rd_en=1, instr_byte<=rom_data; next F2.
REQ-022 F2: rom_addr=pc+2, rom_rd_en=1, operand1<=rom_data; next F3.
REQ-023 F3: rom_rd_en=0, operand2<=rom_data; next ISSUE.
REQ-024 ISSUE: cmd_start=1 for exactly this cycle; next EXEC; cmd_start 0 in all other states.
REQ-025 Latency: cmd_start asserted 4 cycles after entering F0 (F0,F1,F2,F3 then ISSUE).
REQ-026 EXEC: wait for exec_done; rom_rd_en=0; instr_byte/operand1/operand2 held stable.
REQ-027 On exec_done in EXEC, priority: pc_hlt -> HALT, pc unchanged; else jmp_en -> pc<=jmp_addr; else pc<=pc+instr_size.
REQ-028 instr_size=0 treated as 1.
REQ-029 All address arithmetic modulo 512; pc+1, pc+2 and pc+instr_size wrap (pc=9'h1FF, size 2 -> 9'h001).
REQ-030 After non-halt exec_done: next state F0 if run_en=1, else IDLE.
REQ-031 run_en falling in F0..EXEC does not abort; current instruction completes.
REQ-032 exec_done outside EXEC ignored; no PC or state change.
REQ-033 retired increments by 1 on every exec_done accepted in EXEC, including halting instruction; saturates.
REQ-034 HALT: rom_rd_en=0, halted=1; exit only via sys_rst.
REQ-035 Output registers instr_byte/operand1/operand2 change only in F1/F2/F3 respectively.

Reset
REQ-036 sys_rst=1 asynchronously forces state=IDLE, pc=RESET_PC, instr_byte/operand1/operand2=8'h00, cmd_start=0, rom_rd_en=0, rom_addr=0, halted=0, retired=0.
REQ-037 Reset mid-fetch or mid-EXEC abandons instruction; no retired increment; after release, fetch restarts from RESET_PC when run_en=1.

Verification
REQ-038 ROM[0..2]=01,AA,BB, run_en=1 from reset release -> cmd_start one cycle, 4 cycles after F0; instr_byte=01, operand1=AA, operand2=BB.
REQ-039 exec_done with instr_size=2, jmp_en=0 at pc=0 -> pc=002, next fetch reads addresses 002,003,004; retired=1.
REQ-040 exec_done with jmp_en=1, jmp_addr=9'h150, instr_size=3 -> pc=150, next rom_addr sequence 150,151,152.
REQ-041 pc=9'h1FE, instr_size=3 -> fetch addresses 1FE,1FF,000; next pc=001.
REQ-042 exec_done with pc_hlt=1 and jmp_en=1 -> halted=1, pc unchanged, no further rom_rd_en; later exec_done ignored; sys_rst returns pc=000, halted=0.
REQ-043 run_en dropped during EXEC -> instruction completes on exec_done, unit enters IDLE, no rom_rd_en; run_en reasserted -> fetch resumes at updated pc.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: ROM read port, decoder handshake and status.
// master = fetch_unit, slave = ROM/decoder side.
interface fetch_unit_if;
  logic        run_en;
  logic [8:0]  rom_addr;
  logic        rom_rd_en;
  logic [7:0]  rom_data;
  logic [7:0]  instr_byte;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic        cmd_start;
  logic        exec_done;
  logic [1:0]  instr_size;
  logic        jmp_en;
  logic [8:0]  jmp_addr;
  logic        pc_hlt;
  logic [8:0]  pc;
  logic        halted;
  logic [15:0] retired;

  modport master (
    input  run_en, rom_data, exec_done, instr_size, jmp_en, jmp_addr, pc_hlt,
    output rom_addr, rom_rd_en, instr_byte, operand1, operand2, cmd_start,
           pc, halted, retired
  );

  modport slave (
    output run_en, rom_data, exec_done, instr_size, jmp_en, jmp_addr, pc_hlt,
    input  rom_addr, rom_rd_en, instr_byte, operand1, operand2, cmd_start,
           pc, halted, retired
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads opcode plus two operand bytes from a
// one-cycle-latency ROM, issues them to the decoder and advances the PC.
module fetch_unit #(
  parameter logic [8:0] RESET_PC = 9'h000
) (
  input  logic         clk,
  input  logic         sys_rst,
  fetch_unit_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_F0    = 3'd1;
  localparam logic [2:0] S_F1    = 3'd2;
  localparam logic [2:0] S_F2    = 3'd3;
  localparam logic [2:0] S_F3    = 3'd4;
  localparam logic [2:0] S_ISSUE = 3'd5;
  localparam logic [2:0] S_EXEC  = 3'd6;
  localparam logic [2:0] S_HALT  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [8:0]  pc_q, pc_d;
  logic [7:0]  instr_byte_q, instr_byte_d;
  logic [7:0]  operand1_q, operand1_d;
  logic [7:0]  operand2_q, operand2_d;
  logic [15:0] retired_q, retired_d;
  logic [8:0]  size_ext;

  // A zero-length instruction would stall the PC forever, so it counts as one byte.
  assign size_ext = (bus.instr_size == 2'd0) ? 9'd1 : {7'd0, bus.instr_size};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    instr_byte_d = instr_byte_q;
    operand1_d   = operand1_q;
    operand2_d   = operand2_q;
    retired_d    = retired_q;

    case (state_q)
      S_IDLE:  if (bus.run_en) state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1: begin
        instr_byte_d = bus.rom_data;
        state_d      = S_F2;
      end
      S_F2: begin
        operand1_d = bus.rom_data;
        state_d    = S_F3;
      end
      S_F3: begin
        operand2_d = bus.rom_data;
        state_d    = S_ISSUE;
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.exec_done) begin
          if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
          if (bus.pc_hlt) begin
            state_d = S_HALT;
          end else begin
            pc_d    = bus.jmp_en ? bus.jmp_addr : pc_q + size_ext;
            state_d = bus.run_en ? S_F0 : S_IDLE;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_byte_q <= 8'h00;
      operand1_q   <= 8'h00;
      operand2_q   <= 8'h00;
      retired_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_byte_q <= instr_byte_d;
      operand1_q   <= operand1_d;
      operand2_q   <= operand2_d;
      retired_q    <= retired_d;
    end
  end

  // ROM strobe and address decode straight from state; 9-bit adds wrap modulo 512.
  always_comb begin
    bus.rom_addr  = 9'h000;
    bus.rom_rd_en = 1'b0;
    case (state_q)
      S_F0: begin
        bus.rom_addr  = pc_q;
        bus.rom_rd_en = 1'b1;
      end
      S_F1: begin
        bus.rom_addr  = pc_q + 9'd1;
        bus.rom_rd_en = 1'b1;
      end
      S_F2: begin
        bus.rom_addr  = pc_q + 9'd2;
        bus.rom_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cmd_start  = (state_q == S_ISSUE);
  assign bus.halted     = (state_q == S_HALT);
  assign bus.pc         = pc_q;
  assign bus.instr_byte = instr_byte_q;
  assign bus.operand1   = operand1_q;
  assign bus.operand2   = operand2_q;
  assign bus.retired    = retired_q;

endmodule
